// File: rtl/hist_cdf_reader.sv
// Sequential histogram readout that streams the running CDF over valid/ready.
// Optional macro HIST_CDF_CLEAR_ON_READ_EN adds a zero-write port that clears each bin after it is read.
module hist_cdf_reader #(
    parameter int BINS   = 256,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16,
    parameter int CDF_W  = 24,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CNT_W-1:0]  rd_data,
    output logic              cdf_valid,
    input  logic              cdf_ready,
    output logic [ADDR_W-1:0] cdf_bin,
    output logic [CDF_W-1:0]  cdf_value,
    output logic              cdf_last,
    output logic [CDF_W-1:0]  total_count
`ifdef HIST_CDF_CLEAR_ON_READ_EN
    ,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
`endif
);

    localparam int                LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, FIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] bin;
    logic [CDF_W-1:0]  acc;
    logic [LAT_W-1:0]  lat_cnt;
    logic              wait_last;

    // Widen by one bit so overflow is visible, then clamp instead of wrapping.
    function automatic logic [CDF_W-1:0] sat_add(input logic [CDF_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CDF_W:0] sum;
        sum = {1'b0, a} + (CDF_W + 1)'(b);
        return sum[CDF_W] ? {CDF_W{1'b1}} : sum[CDF_W-1:0];
    endfunction

    assign wait_last = (state == WAIT) && (lat_cnt == LAT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        rd_en     = 1'b0;
        cdf_valid = 1'b0;
        cdf_last  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                rd_en     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (wait_last) state_nxt = OUT;
            OUT: begin
                cdf_valid = 1'b1;
                cdf_last  = (bin == LAST_BIN);
                if (cdf_ready) state_nxt = (bin == LAST_BIN) ? FIN : ISSUE;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // bin only moves on a handshake, so the address and CDF word stay stable through stalls.
    assign rd_addr   = bin;
    assign cdf_bin   = bin;
    assign cdf_value = acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin         <= '0;
            acc         <= '0;
            lat_cnt     <= '0;
            total_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    bin <= '0;
                    acc <= '0;
                end
                ISSUE: lat_cnt <= '0;
                WAIT: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    if (wait_last) acc <= sat_add(acc, rd_data);
                end
                OUT: if (cdf_ready && (bin != LAST_BIN)) bin <= bin + ADDR_W'(1);
                FIN: total_count <= acc;
                default: ;
            endcase
        end
    end

`ifdef HIST_CDF_CLEAR_ON_READ_EN
    // Pulse fires on entry to OUT only, so a stalled word never re-issues the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_we   <= 1'b0;
            clr_addr <= '0;
        end else begin
            clr_we <= wait_last;
            if (wait_last) clr_addr <= bin;
        end
    end
`endif

endmodule

// File: doc/hist_cdf_reader.md
Name: hist_cdf_reader

Overview:
Sequential reader for the 256-bin luminance histogram memory that the per-pixel accumulator writes during a frame. After the frame, the control logic pulses start. The block then reads bins 0..BINS-1 in order, one at a time, over a fixed-latency read port. It accumulates the cumulative distribution (CDF) and streams one CDF word per bin on a valid/ready interface to the equalisation LUT builder.

Parameters:
BINS, 256, number of histogram bins (power of two)
ADDR_W, 8, bin address width, log2(BINS)
CNT_W, 16, width of one histogram bin count
CDF_W, 24, width of the cumulative sum (covers 1920x1080 = 2,073,600)
RD_LAT, 1, histogram memory read latency in cycles (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin a readout pass
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the pass completes
rd_en  out  1  histogram memory read enable
rd_addr  out  ADDR_W  histogram memory read address
rd_data  in  CNT_W  histogram bin count, valid RD_LAT cycles after the rd_en cycle
cdf_valid  out  1  CDF word available
cdf_ready  in  1  downstream accepts the CDF word
cdf_bin  out  ADDR_W  bin index of the current CDF word
cdf_value  out  CDF_W  cumulative count of bins 0..cdf_bin
cdf_last  out  1  high with cdf_valid when cdf_bin == BINS-1
total_count  out  CDF_W  final CDF of the last completed pass (pixel total)

Behaviour:
- Reset (async, active-high): FSM=IDLE; bin counter, accumulator and total_count = 0; busy, done, rd_en, cdf_valid, cdf_last = 0; rd_addr, cdf_bin, cdf_value = 0. Reset mid-pass abandons the pass with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, OUT, FIN.
- IDLE: start=1 -> bin=0, acc=0, go to ISSUE. start in any other state is ignored.
- ISSUE (1 cycle): rd_en=1, rd_addr=bin, then WAIT. rd_en is 0 in all other states; rd_addr holds its value.
- WAIT (RD_LAT cycles, internal latency counter):
  - At the clock edge ending the last WAIT cycle, acc <= acc + zero-extended rd_data.
  - The sum saturates at 2^CDF_W-1 and never wraps.
  - Then go to OUT.
- OUT:
  - cdf_valid=1, cdf_value=acc, cdf_bin=bin, cdf_last=(bin==BINS-1).
  - All four outputs stay stable while cdf_valid=1 and cdf_ready=0.
  - On cdf_valid&cdf_ready: if cdf_last, go to FIN; else bin<=bin+1 and go to ISSUE.
  - bin never wraps within a pass.
- FIN (1 cycle): done=1, total_count<=acc, cdf_valid=0, then IDLE. total_count holds until the next FIN or reset.
- busy=1 in ISSUE, WAIT, OUT and FIN; 0 in IDLE.
- Throughput with cdf_ready held 1: 2+RD_LAT cycles per bin.
  - Full pass at defaults = 768 cycles from the first ISSUE to the last handshake, plus 1 FIN cycle.
  - start to first cdf_valid = 1+1+RD_LAT cycles.
- cdf_ready asserted while cdf_valid=0 has no effect. cdf_ready may depend combinationally on cdf_valid.
- Reads occur only in ISSUE, so the memory sees at most one outstanding read.

Optional Feature:
Macro HIST_CDF_CLEAR_ON_READ_EN.
- Defined:
  - Adds output clr_we (1) and output clr_addr (ADDR_W); both reset to 0.
  - In the first cycle of each OUT state, clr_we=1 and clr_addr=bin. This commands the histogram memory to write zero to the bin just read, so the histogram is empty for the next frame with no separate clear pass.
  - clr_we is a single-cycle pulse per bin, regardless of stalls. It never coincides with rd_en.
- Not defined: the ports are absent, and the histogram contents are untouched by this block.

Test Plan:
- Memory model holds bin[i]=1 for all i, RD_LAT=1, cdf_ready=1; pulse start -> 256 words with cdf_value=i+1 and cdf_bin=i. cdf_last only on bin 255. done exactly 769 cycles after the start cycle. total_count=256.
- bin[0]=100, bin[128]=50, bin[255]=7, others 0 -> cdf_value=100 for bins 0..127, 150 for bins 128..254, 157 for bin 255. total_count=157.
- cdf_ready toggled with a pseudo-random pattern (~50% duty) -> cdf_bin/value/last stay stable during stalls, and no bin is skipped or duplicated. The result matches the first scenario.
- Every bin = 16'hFFFF with CDF_W=16 -> cdf_value saturates at 16'hFFFF from bin 1 onward, with no wrap.
- Reset asserted mid-pass at bin 40, then start pulsed again -> all outputs 0 immediately and no done pulse. The new pass restarts at bin 0 with acc=0. start pulses during busy are ignored.
- With HIST_CDF_CLEAR_ON_READ_EN defined -> one clr_we pulse per bin with clr_addr=bin, 256 in total. A second pass over the cleared model memory yields all cdf_value=0 and total_count=0.
